// File: rtl/program_counter_ras_pkg.sv
// pc_pkg: shared constants and types for the program counter slice.
//   INSTR_BYTES  - fixed instruction size used for sequential advance
//   DEFAULT_XLEN - default address/data width
//   pc_src_e     - selects which source loads the PC on a write edge
package pc_pkg;

  localparam int INSTR_BYTES  = 4;
  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [1:0] {
    PC_SRC_SEQ,
    PC_SRC_JUMP,
    PC_SRC_TRAP,
    PC_SRC_EPC
  } pc_src_e;

endpackage

// File: rtl/program_counter_ras_if.sv
// program_counter_ras_if: control/status bundle between the control unit
// (master) and the program counter (slave).
//   master drives: write, jump, use_offset, address_in_to_AD, address_in,
//                  trap, trap_return, ras_push, ras_pop
//   slave drives:  next, current, last, epc, AD_Bus, data_offset,
//                  misaligned, ras_top, ras_empty
interface program_counter_ras_if #(
  parameter int XLEN = 32
);

  logic            write;
  logic            jump;
  logic            use_offset;
  logic            address_in_to_AD;
  logic [XLEN-1:0] address_in;
  logic            trap;
  logic            trap_return;
  logic            ras_push;
  logic            ras_pop;

  logic [XLEN-1:0] next;
  logic [XLEN-1:0] current;
  logic [XLEN-1:0] last;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] AD_Bus;
  logic [1:0]      data_offset;
  logic            misaligned;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;

  modport master (
    output write, jump, use_offset, address_in_to_AD, address_in,
           trap, trap_return, ras_push, ras_pop,
    input  next, current, last, epc, AD_Bus, data_offset,
           misaligned, ras_top, ras_empty
  );

  modport slave (
    input  write, jump, use_offset, address_in_to_AD, address_in,
           trap, trap_return, ras_push, ras_pop,
    output next, current, last, epc, AD_Bus, data_offset,
           misaligned, ras_top, ras_empty
  );

endinterface

// File: rtl/program_counter_ras_return_stack.sv
// pc_return_stack: circular return-address stack.
//   clock, reset  - clock and asynchronous active-high reset
//   push, pop     - qualified stack operations (already gated by write/trap)
//   push_value    - address written on push
//   top           - current top entry, zero when empty
//   empty         - no valid entries
// The pointer always addresses the top entry; a push past RAS_DEPTH wraps
// and silently overwrites the oldest entry while the count saturates.
module pc_return_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_value,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [XLEN-1:0]  entries_q [RAS_DEPTH];
  logic [XLEN-1:0]  entries_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Push+pop together replaces the top entry in place (call straight after
  // a return); a pop on an empty stack is dropped.
  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    if (push && pop) begin
      entries_d[ptr_q] = push_value;
    end else if (push) begin
      ptr_d            = ptr_q + PTR_ONE;
      entries_d[ptr_d] = push_value;
      if (count_q != FULL) count_d = count_q + CNT_ONE;
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_q - PTR_ONE;
      count_d = count_q - CNT_ONE;
    end
  end

  // Pointer resets to the last slot so the first push lands in slot 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= '1;
      count_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign empty = (count_q == '0);
  assign top   = empty ? '0 : entries_q[ptr_q];

endmodule

// File: rtl/program_counter_ras.sv
// program_counter_ras: fetch-stage program counter with jumps, trap
// entry/return and an optional return-address stack.
//   clock, reset - clock and asynchronous active-high reset
//   bus          - program_counter_ras_if.slave carrying control inputs
//                  (write, jump, use_offset, address_in_to_AD, address_in,
//                  trap, trap_return, ras_push, ras_pop) and PC outputs
//                  (next, current, last, epc, AD_Bus, data_offset,
//                  misaligned, ras_top, ras_empty)
// Build option: define PROGRAM_COUNTER_RAS_EN to include the return stack;
// otherwise ras_top reads 0 and ras_empty reads 1.
module program_counter_ras
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0010),
  parameter int              RAS_DEPTH    = 4
) (
  input logic                clock,
  input logic                reset,
  program_counter_ras_if.slave bus
);

  logic [XLEN-1:0] current_q, current_d;
  logic [XLEN-1:0] last_q, last_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] addr_calc;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            take_trap;
  pc_src_e         pc_src;

  assign addr_calc   = bus.use_offset ? (current_q + bus.address_in) : bus.address_in;
  assign jump_target = {addr_calc[XLEN-1:1], 1'b0};
  assign next_pc     = current_q + XLEN'(INSTR_BYTES);
  assign misaligned  = bus.jump & jump_target[1];

  // A misaligned jump becomes a trap, but only when the jump would actually
  // win the priority, i.e. no trap_return is pending.
  assign take_trap = bus.trap | (misaligned & ~bus.trap_return);

  // Source select and register next-state; everything holds without write.
  always_comb begin
    pc_src    = PC_SRC_SEQ;
    current_d = current_q;
    last_d    = last_q;
    epc_d     = epc_q;
    if (take_trap)            pc_src = PC_SRC_TRAP;
    else if (bus.trap_return) pc_src = PC_SRC_EPC;
    else if (bus.jump)        pc_src = PC_SRC_JUMP;
    if (bus.write) begin
      last_d = current_q;
      case (pc_src)
        PC_SRC_TRAP: begin
          epc_d     = current_q;
          current_d = TRAP_VECTOR;
        end
        PC_SRC_EPC:  current_d = epc_q;
        PC_SRC_JUMP: current_d = jump_target;
        default:     current_d = next_pc;
      endcase
    end
  end

  // PC register file with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      current_q <= RESET_VECTOR;
      last_q    <= RESET_VECTOR;
      epc_q     <= '0;
    end else begin
      current_q <= current_d;
      last_q    <= last_d;
      epc_q     <= epc_d;
    end
  end

  assign bus.next        = next_pc;
  assign bus.current     = current_q;
  assign bus.last        = last_q;
  assign bus.epc         = epc_q;
  assign bus.AD_Bus      = bus.address_in_to_AD ? {addr_calc[XLEN-1:2], 2'b00} : current_q;
  assign bus.data_offset = bus.address_in_to_AD ? addr_calc[1:0] : 2'b00;
  assign bus.misaligned  = misaligned;

`ifdef PROGRAM_COUNTER_RAS_EN
  logic ras_push_en;
  logic ras_pop_en;

  // Stack operations only commit on a write edge that does not trap.
  assign ras_push_en = bus.write & ~take_trap & bus.ras_push;
  assign ras_pop_en  = bus.write & ~take_trap & bus.ras_pop;

  pc_return_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_return_stack (
    .clock      (clock),
    .reset      (reset),
    .push       (ras_push_en),
    .pop        (ras_pop_en),
    .push_value (next_pc),
    .top        (bus.ras_top),
    .empty      (bus.ras_empty)
  );
`else
  logic unused_ras_ctrl;
  assign unused_ras_ctrl = bus.ras_push ^ bus.ras_pop;
  assign bus.ras_top     = '0;
  assign bus.ras_empty   = 1'b1;
`endif

endmodule

// File: doc/program_counter_ras.md
# program_counter_ras

Parametrised next-generation program counter for the fetch stage. Holds current/last/next PC, resolves absolute or PC-relative jumps, drives the aligned address bus with byte offset, and adds trap entry/return with a saved exception PC. Optionally carries a circular return-address stack (RAS) for call/return prediction. It sits between the control unit and the memory address bus.

## Interface
- XLEN, 32, address/data width (≥ 8)
- RESET_VECTOR, 0, value loaded into current on reset
- TRAP_VECTOR, 32'h0000_0010, trap entry address
- RAS_DEPTH, 4, return-stack entries (power of two, ≥ 2)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- write  in  1  commit PC update on this edge
- jump  in  1  select jump target instead of sequential
- use_offset  in  1  target/bus address = current + address_in (else address_in)
- address_in_to_AD  in  1  AD_Bus shows computed address instead of current
- address_in  in  XLEN  absolute address or signed offset
- trap  in  1  take trap on write
- trap_return  in  1  return to epc on write
- ras_push  in  1  push next on write (call)
- ras_pop  in  1  pop on write (return)
- next  out  XLEN  current + 4
- current  out  XLEN  PC register
- last  out  XLEN  PC before most recent update
- epc  out  XLEN  saved trap PC
- AD_Bus  out  XLEN  word-aligned bus address
- data_offset  out  2  byte offset of bus address
- misaligned  out  1  jump target bit 1 set (combinational)
- ras_top  out  XLEN  predicted return address
- ras_empty  out  1  stack empty

## Operation
- Computed address A = use_offset ? current + address_in : address_in, modulo 2^XLEN; jump target T = {A[XLEN-1:1],1'b0}.
- AD_Bus = address_in_to_AD ? {A[XLEN-1:2],2'b00} : current; data_offset = address_in_to_AD ? A[1:0] : 2'b00.
- misaligned = jump & T[1]; a misaligned jump on write instead enters trap (current←TRAP_VECTOR, epc←current).
- Update priority on write edge: trap > trap_return > jump > sequential.
  - trap: epc←current, current←TRAP_VECTOR.
  - trap_return: current←epc.
  - jump: current←T. sequential: current←next.
  - Every update: last←current.
- No write: all registers hold; combinational outputs still track inputs.
- RAS (circular, pointer + count): push writes next, count saturates at RAS_DEPTH, oldest overwritten on overflow; pop on empty ignored; push+pop same edge replaces top with next, count unchanged. RAS acts only when write=1 and no trap.
- ras_top = top entry, 0 when empty.

## Timing
- Reset (async, immediate): current=RESET_VECTOR, last=RESET_VECTOR, epc=0, RAS count=0, ras_empty=1, ras_top=0; next=RESET_VECTOR+4; AD_Bus=current, data_offset=0, misaligned=0 (inputs low).
- Register updates one edge after write sampled high; outputs valid next cycle. next, AD_Bus, data_offset, misaligned, ras_top are zero-latency combinational from registers/inputs.
- Reset asserted mid-operation overrides a same-cycle write; release resumes sequential on the next write edge.
- Wrap: current = 2^XLEN-4 sequential → 0.

## Configuration
- PROGRAM_COUNTER_RAS_EN defined: RAS instantiated as above.
- Undefined: no stack storage; ras_push/ras_pop ignored; ras_top=0, ras_empty=1 constantly; all other behaviour identical.

## Structure
- Package pc_pkg: INSTR_BYTES=4, default XLEN, enum pc_src_e {PC_SRC_SEQ, PC_SRC_JUMP, PC_SRC_TRAP, PC_SRC_EPC} used for the update mux.
- Sub-module pc_return_stack (XLEN, RAS_DEPTH): storage, pointer, count, push/pop, top/empty; instantiated only under the macro.

## Test plan
- Reset, then 4 writes → current 0,4,8,12,16; last lags by one; next = current+4.
- address_in=0x20, jump, write → current=0x20, last=0x10; use_offset with address_in=0xFFFF_FFF0 from 0x20 → current=0x10.
- address_in_to_AD, use_offset, address_in=0x11/0x12/0x13 from current 0x10 → AD_Bus=0x20, data_offset=01/10/11; current unchanged without write.
- trap at current=0x40 → current=0x10, epc=0x40; trap_return → current=0x40; jump to 0x22 → misaligned=1, trap taken.
- RAS (macro on): 5 pushes from 0x100 step 4 with depth 4 → pops return 0x114,0x110,0x10C,0x108 then empty; pop on empty leaves state.
- Reset asserted with write=1 mid-run → current=RESET_VECTOR immediately, epc=0, ras_empty=1.
